// File: rtl/cpu_defines_pkg.sv
// Shared CPU types for the fetch front end: stall vector, address/word,
// exception codes and the IF state encoding.
`ifndef PC_RESET_ADDR
`define PC_RESET_ADDR 32'h8000_0000
`endif

package cpu_defines;

    typedef logic [5:0]  Stall_t;
    typedef logic [31:0] Inst_addr_t;
    typedef logic [31:0] Word_t;

    typedef enum logic [3:0] {
        EXC_NO            = 4'd0,
        EXC_INST_ADDR_ERR = 4'd1,
        EXC_ILLEGAL_INST  = 4'd2,
        EXC_SYSCALL       = 4'd3
    } Excp_t;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_REQ,
        IF_HOLD
    } IfState_t;

    typedef struct packed {
        Inst_addr_t pc;
        Word_t      inst;
    } if_id_t;

    localparam int STALL_PC = 0;
    localparam int STALL_ID = 1;

endpackage

// File: rtl/if_fetch_hold_buf.sv
// One-entry {pc, inst} skid buffer that parks a fetched word
// while the PC stage is stalled.
module if_hold_buf
    import cpu_defines::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   drop,
    input  if_id_t din,
    output if_id_t dout,
    output logic   valid
);

    if_id_t data_q;
    logic   valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            if (drop) begin
                valid_q <= 1'b0;
            end else if (load) begin
                data_q  <= din;
                valid_q <= 1'b1;
            end
        end
    end

    assign dout  = data_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: PC owner and instruction-bus handshake.
// Optional IF_ALIGN_CHECK_EN raises EXC_INST_ADDR_ERR on misaligned PCs.
module if_fetch
    import cpu_defines::*;
#(
    parameter Inst_addr_t RESET_PC = `PC_RESET_ADDR,
    parameter Inst_addr_t PC_INC   = 32'd4
) (
    input  logic       clk,
    input  logic       rst,
    input  Stall_t     stall,
    input  logic       flush,
    input  Inst_addr_t new_pc,
    input  logic       branch_flag_i,
    input  Inst_addr_t branch_target_i,
    output logic       inst_req_o,
    output Inst_addr_t inst_addr_o,
    input  logic       inst_ack_i,
    input  Word_t      inst_rdata_i,
    output logic       stallreq_o,
    output logic       inst_valid_o,
    output Word_t      inst_o,
    output Inst_addr_t inst_pc_o,
    output Excp_t      excp_o
);

    IfState_t   state;
    Inst_addr_t pc_q;
    Inst_addr_t pend_pc;
    logic       kill_q;
    logic       err_q;

    logic       in_req;
    logic       in_hold;
    logic       misalign;
    logic       br_take;
    logic       redirect;
    Inst_addr_t redir_pc;
    Inst_addr_t seq_pc;
    logic       ack;
    logic       take_bus;
    logic       take_buf;
    logic       err_valid;

    logic       hb_load;
    logic       hb_drop;
    logic       hb_valid;
    if_id_t     hb_din;
    if_id_t     hb_dout;

    logic       unused_stall;

    assign unused_stall = ^stall[5:2];

    assign in_req  = (state == IF_REQ);
    assign in_hold = (state == IF_HOLD);

`ifdef IF_ALIGN_CHECK_EN
    assign misalign    = (pc_q[1:0] != 2'b00);
    assign inst_addr_o = pc_q;
`else
    assign misalign    = 1'b0;
    assign inst_addr_o = {pc_q[31:2], 2'b00};
`endif

    // flush outranks a branch; a branch only counts while ID is moving
    assign br_take  = branch_flag_i & ~stall[STALL_ID];
    assign redirect = flush | br_take;
    assign redir_pc = flush ? new_pc : branch_target_i;
    assign seq_pc   = pc_q + PC_INC;

    assign inst_req_o = in_req & ~misalign;
    assign stallreq_o = inst_req_o & ~inst_ack_i;
    assign ack        = inst_req_o & inst_ack_i;

    assign take_bus  = ack & ~kill_q & ~redirect & ~stall[STALL_PC];
    assign take_buf  = in_hold & hb_valid & ~redirect & ~stall[STALL_PC];
    assign err_valid = err_q & ~flush;

    assign hb_load = ack & ~kill_q & ~redirect & stall[STALL_PC];
    assign hb_drop = in_hold & (redirect | ~stall[STALL_PC]);
    assign hb_din  = '{pc: pc_q, inst: inst_rdata_i};

    if_hold_buf u_hold_buf (
        .clk   (clk),
        .rst   (rst),
        .load  (hb_load),
        .drop  (hb_drop),
        .din   (hb_din),
        .dout  (hb_dout),
        .valid (hb_valid)
    );

    always_comb begin
        inst_valid_o = take_bus | take_buf | err_valid;
        inst_o       = '0;
        inst_pc_o    = '0;
        excp_o       = EXC_NO;
        unique case (1'b1)
            take_bus: begin
                inst_o    = inst_rdata_i;
                inst_pc_o = pc_q;
            end
            take_buf: begin
                inst_o    = hb_dout.inst;
                inst_pc_o = hb_dout.pc;
            end
            err_valid: begin
                inst_pc_o = pc_q;
                excp_o    = EXC_INST_ADDR_ERR;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IF_IDLE;
            pc_q    <= RESET_PC;
            pend_pc <= '0;
            kill_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state)
                IF_IDLE: begin
                    state <= IF_REQ;
                    if (redirect) pc_q <= redir_pc;
                end
                IF_REQ: begin
                    if (misalign) begin
                        // parked on the bad PC until ctrl flushes
                        if (flush) begin
                            pc_q  <= new_pc;
                            err_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end else if (ack) begin
                        if (redirect) begin
                            pc_q   <= redir_pc;
                            kill_q <= 1'b0;
                        end else if (kill_q) begin
                            pc_q   <= pend_pc;
                            kill_q <= 1'b0;
                        end else if (stall[STALL_PC]) begin
                            state <= IF_HOLD;
                        end else begin
                            pc_q <= seq_pc;
                        end
                    end else if (redirect) begin
                        // bus keeps the old address; its word gets discarded
                        pend_pc <= redir_pc;
                        kill_q  <= 1'b1;
                    end
                end
                IF_HOLD: begin
                    if (redirect) begin
                        pc_q  <= redir_pc;
                        state <= IF_REQ;
                    end else if (!stall[STALL_PC]) begin
                        pc_q  <= seq_pc;
                        state <= IF_REQ;
                    end
                end
                default: state <= IF_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed cycle table, reset/alignment sequences,
// then random bus/stall/redirect traffic against a fetch-stream model.
module tb_if_fetch;
    import cpu_defines::*;

    localparam Inst_addr_t B = 32'h8000_0000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    Stall_t     stall;
    logic       flush;
    Inst_addr_t new_pc;
    logic       branch_flag_i;
    Inst_addr_t branch_target_i;
    logic       inst_req_o;
    Inst_addr_t inst_addr_o;
    logic       inst_ack_i;
    Word_t      inst_rdata_i;
    logic       stallreq_o;
    logic       inst_valid_o;
    Word_t      inst_o;
    Inst_addr_t inst_pc_o;
    Excp_t      excp_o;

    int n_cmp = 0;
    int n_bad = 0;

    if_fetch #(.RESET_PC(B), .PC_INC(32'd4)) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .flush           (flush),
        .new_pc          (new_pc),
        .branch_flag_i   (branch_flag_i),
        .branch_target_i (branch_target_i),
        .inst_req_o      (inst_req_o),
        .inst_addr_o     (inst_addr_o),
        .inst_ack_i      (inst_ack_i),
        .inst_rdata_i    (inst_rdata_i),
        .stallreq_o      (stallreq_o),
        .inst_valid_o    (inst_valid_o),
        .inst_o          (inst_o),
        .inst_pc_o       (inst_pc_o),
        .excp_o          (excp_o)
    );

    always #5 clk = ~clk;

    // memory contents seen on the bus: a fixed function of address
    function automatic Word_t mem(Inst_addr_t a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic       ack;
        Stall_t     stall;
        logic       flush;
        Inst_addr_t npc;
        logic       br;
        Inst_addr_t tgt;
        logic       req;
        Inst_addr_t addr;
        logic       sr;
        logic       v;
        Inst_addr_t pc;
    } vec_t;

    function automatic vec_t mk(logic a, Stall_t s, logic f,
                                Inst_addr_t np, logic b, Inst_addr_t t,
                                logic rq, Inst_addr_t ad, logic sr,
                                logic v, Inst_addr_t pc);
        vec_t r;
        r.ack = a; r.stall = s; r.flush = f; r.npc = np;
        r.br = b; r.tgt = t; r.req = rq; r.addr = ad;
        r.sr = sr; r.v = v; r.pc = pc;
        return r;
    endfunction

    task automatic drive(logic a, Stall_t s, logic f, Inst_addr_t np,
                         logic b, Inst_addr_t t);
        inst_ack_i      = a;
        stall           = s;
        flush           = f;
        new_pc          = np;
        branch_flag_i   = b;
        branch_target_i = t;
        inst_rdata_i    = a ? mem(inst_addr_o) : 32'hDEAD_BEEF;
    endtask

    initial begin
        vec_t       tab[$];
        Stall_t     S = 6'b001111;
        Inst_addr_t exp_pc;
        Inst_addr_t p_addr;
        logic       p_req;
        logic       p_ack;
        logic       s0;
        logic       s1;
        logic       redir;
        int         ndel;

        // ack  stall fl  npc              br  tgt      | req addr           sr  v  pc
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  0, B,            0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B,            0, 1, B));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 4,        0, 1, B + 4));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 8,        0, 1, B + 8));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  1, B + 'hC,      1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  1, B + 'hC,      1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  1, B + 'hC,      1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 'hC,      0, 1, B + 'hC));
        tab.push_back(mk(0, 0, 0, 0, 1, B + 'h100,          1, B + 'h10,     1, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  1, B + 'h10,     1, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 'h10,     0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 'h100,    0, 1, B + 'h100));
        tab.push_back(mk(1, S, 0, 0, 0, 0,                  1, B + 'h104,    0, 0, 0));
        tab.push_back(mk(0, S, 0, 0, 0, 0,                  0, B + 'h104,    0, 0, 0));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  0, B + 'h104,    0, 1, B + 'h104));
        tab.push_back(mk(1, S, 0, 0, 0, 0,                  1, B + 'h108,    0, 0, 0));
        tab.push_back(mk(0, 0, 1, B + 'h180, 0, 0,          0, B + 'h108,    0, 0, 0));
        tab.push_back(mk(1, 0, 1, B + 'h180, 0, 0,          1, B + 'h180,    0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, B + 'h180,    0, 1, B + 'h180));
        tab.push_back(mk(1, 0, 1, 32'hFFFF_FFFC, 0, 0,      1, B + 'h184,    0, 0, 0));
        tab.push_back(mk(1, 0, 0, 0, 0, 0,                  1, 32'hFFFF_FFFC, 0, 1, 32'hFFFF_FFFC));
        tab.push_back(mk(0, 0, 0, 0, 0, 0,                  1, 32'h0,        1, 0, 0));

        drive(0, 0, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_req", inst_req_o, 0);
        chk("rst_valid", inst_valid_o, 0);
        chk("rst_stallreq", stallreq_o, 0);
        chk("rst_inst", inst_o, 0);
        chk("rst_pc", inst_pc_o, 0);
        chk("rst_excp", 32'(excp_o), 32'(EXC_NO));

        rst = 1'b1;
        foreach (tab[i]) begin
            drive(tab[i].ack, tab[i].stall, tab[i].flush, tab[i].npc,
                  tab[i].br, tab[i].tgt);
            #2;
            chk($sformatf("row%0d_req", i), inst_req_o, tab[i].req);
            chk($sformatf("row%0d_addr", i), inst_addr_o, tab[i].addr);
            chk($sformatf("row%0d_stallreq", i), stallreq_o, tab[i].sr);
            chk($sformatf("row%0d_valid", i), inst_valid_o, tab[i].v);
            chk($sformatf("row%0d_pc", i), inst_pc_o, tab[i].pc);
            chk($sformatf("row%0d_inst", i), inst_o,
                tab[i].v ? mem(tab[i].pc) : 32'h0);
            chk($sformatf("row%0d_excp", i), 32'(excp_o), 32'(EXC_NO));
            @(negedge clk);
        end

        // reset while a request is outstanding drops it at once
        drive(0, 0, 0, 0, 0, 0);
        rst = 1'b0;
        #1;
        chk("midrst_req", inst_req_o, 0);
        chk("midrst_valid", inst_valid_o, 0);
        chk("midrst_addr", inst_addr_o, B);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        drive(1, 0, 0, 0, 1, B + 'h102);
        #2;
        chk("mis_br_valid", inst_valid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
`ifdef IF_ALIGN_CHECK_EN
        chk("mis_req", inst_req_o, 0);
        chk("mis_stallreq", stallreq_o, 0);
        chk("mis_valid0", inst_valid_o, 0);
        @(negedge clk);
        #2;
        chk("mis_valid", inst_valid_o, 1);
        chk("mis_excp", 32'(excp_o), 32'(EXC_INST_ADDR_ERR));
        chk("mis_pc", inst_pc_o, B + 'h102);
        chk("mis_inst", inst_o, 0);
        chk("mis_req1", inst_req_o, 0);
        @(negedge clk);
        drive(0, 0, 1, B + 'h40, 0, 0);
        #2;
        chk("mis_flush_valid", inst_valid_o, 0);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #2;
        chk("mis_flush_req", inst_req_o, 1);
        chk("mis_flush_addr", inst_addr_o, B + 'h40);
`else
        chk("mis_req", inst_req_o, 1);
        chk("mis_addr", inst_addr_o, B + 'h100);
        chk("mis_excp", 32'(excp_o), 32'(EXC_NO));
`endif

        // random traffic: delivered words must follow the fetch stream
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        exp_pc = B;
        p_req = 1'b0;
        p_ack = 1'b0;
        p_addr = '0;
        ndel = 0;
        for (int i = 0; i < 3000; i++) begin
            s0 = ($urandom % 4 == 0);
            s1 = s0 & $urandom_range(0, 1);
            drive(inst_req_o & ($urandom % 3 != 0),
                  {4'($urandom), s1, s0},
                  ($urandom % 25 == 0),
                  B + 32'($urandom % 1024) * 4,
                  ($urandom % 12 == 0),
                  B + 32'($urandom % 1024) * 4);
            #2;
            redir = flush | (branch_flag_i & ~s1);
            if (p_req && !p_ack) begin
                chk("rnd_req_held", inst_req_o, 1);
                chk("rnd_addr_held", inst_addr_o, p_addr);
            end
            if (redir) chk("rnd_redir_valid", inst_valid_o, 0);
            if (inst_valid_o) begin
                ndel++;
                chk("rnd_pc", inst_pc_o, exp_pc);
                chk("rnd_inst", inst_o, mem(exp_pc));
                chk("rnd_valid_stalled", s0, 0);
            end
            if (flush) exp_pc = new_pc;
            else if (redir) exp_pc = branch_target_i;
            else if (inst_valid_o) exp_pc = exp_pc + 4;
            p_req = inst_req_o;
            p_ack = inst_ack_i;
            p_addr = inst_addr_o;
            @(negedge clk);
        end
        chk("rnd_deliveries", 32'(ndel >= 100), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
